sprite_frame_regs: RTL and testbench

// Avalon-MM write/read slave holding sprite state (Pac-Man position/direction, ghost positions) for the VGA renderer.

---
 rtl/sprite_frame_regs.sv | 183 ++++++++++++++++++
 tb/tb_sprite_frame_regs.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_frame_regs.sv
// Double-buffered sprite register file for the VGA renderer: software writes staging copies, a commit
// request publishes them to the live outputs at the next vblank start. Optional macro: SPRITE_FRAME_REGS_IRQ_EN.
module sprite_frame_regs #(
  parameter int NUM_GHOSTS = 4,
  parameter int VACTIVE    = 480,
  parameter int ANIM_DIV   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic                    read,
  input  logic [4:0]              address,
  input  logic [15:0]             writedata,
  output logic [15:0]             readdata,
  input  logic [10:0]             hcount,
  input  logic [9:0]              vcount,
  output logic [9:0]              pacman_x,
  output logic [9:0]              pacman_y,
  output logic [1:0]              pacman_dir,
  output logic [10*NUM_GHOSTS-1:0] ghost_x,
  output logic [10*NUM_GHOSTS-1:0] ghost_y,
  output logic [1:0]              anim_phase,
  output logic [15:0]             frame_count,
  output logic                    irq
);

  localparam logic [9:0] PAC_X_RST   = 10'd340;
  localparam logic [9:0] PAC_Y_RST   = 10'd240;
  localparam logic [1:0] PAC_DIR_RST = 2'd1;
  localparam logic [9:0] GHOST_X_RST = 10'd300;
  localparam logic [9:0] GHOST_Y_RST = 10'd240;
  localparam logic [4:0] ADDR_CTRL   = 5'd16;
  localparam logic [4:0] ADDR_FRAME  = 5'd17;
  localparam logic [4:0] ADDR_ANIM   = 5'd18;

  // Valid/ready: an access happens in any cycle with chipselect and write (or read) high; the slave is
  // always ready, and readdata for a read appears after the following clock edge and holds until the next read.

  typedef enum logic {IDLE, PENDING} state_t;
  state_t state, state_next;

  logic [9:0] stg_px, stg_py, live_px, live_py;
  logic [1:0] stg_dir, live_dir;
  logic [9:0] stg_gx [NUM_GHOSTS];
  logic [9:0] stg_gy [NUM_GHOSTS];
  logic [9:0] live_gx [NUM_GHOSTS];
  logic [9:0] live_gy [NUM_GHOSTS];
  logic [7:0] div_cnt;
  logic       irq_q;
  logic [15:0] rd_mux;

  logic wr_en, ctrl_wr, vb_pulse, commit;
  assign wr_en    = chipselect & write;
  assign ctrl_wr  = wr_en && (address == ADDR_CTRL) && writedata[0];
  assign vb_pulse = (vcount == 10'(VACTIVE)) && (hcount == 11'd0);
  assign commit   = (state == PENDING) && vb_pulse;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A request arriving on the vblank cycle while idle only arms the next frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl_wr)  state_next = PENDING;
      PENDING: if (vb_pulse) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_px  <= PAC_X_RST;
      stg_py  <= PAC_Y_RST;
      stg_dir <= PAC_DIR_RST;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        stg_gx[i] <= GHOST_X_RST;
        stg_gy[i] <= GHOST_Y_RST;
      end
    end else if (wr_en) begin
      case (address)
        5'd0:    stg_px  <= writedata[9:0];
        5'd1:    stg_py  <= writedata[9:0];
        5'd2:    stg_dir <= writedata[1:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        if (address == 5'(4 + 2*i)) stg_gx[i] <= writedata[9:0];
        if (address == 5'(5 + 2*i)) stg_gy[i] <= writedata[9:0];
      end
    end
  end

  // Live copy samples pre-edge staging, so a staging write on the commit cycle waits for the next commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      live_px  <= PAC_X_RST;
      live_py  <= PAC_Y_RST;
      live_dir <= PAC_DIR_RST;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        live_gx[i] <= GHOST_X_RST;
        live_gy[i] <= GHOST_Y_RST;
      end
    end else if (commit) begin
      live_px  <= stg_px;
      live_py  <= stg_py;
      live_dir <= stg_dir;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        live_gx[i] <= stg_gx[i];
        live_gy[i] <= stg_gy[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      div_cnt     <= '0;
      anim_phase  <= '0;
    end else if (vb_pulse) begin
      frame_count <= frame_count + 16'd1;
      if (div_cnt == 8'(ANIM_DIV - 1)) begin
        div_cnt    <= '0;
        anim_phase <= anim_phase + 2'd1;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

`ifdef SPRITE_FRAME_REGS_IRQ_EN
  logic ack_wr;
  assign ack_wr = wr_en && (address == 5'd19);

  // Set has priority so a commit coinciding with an ack is never lost.
  always_ff @(posedge clk) begin
    if (reset)       irq_q <= 1'b0;
    else if (commit) irq_q <= 1'b1;
    else if (ack_wr) irq_q <= 1'b0;
  end
`else
  assign irq_q = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      5'd0:       rd_mux = {6'b0, stg_px};
      5'd1:       rd_mux = {6'b0, stg_py};
      5'd2:       rd_mux = {14'b0, stg_dir};
      ADDR_CTRL:  rd_mux = {14'b0, irq_q, state == PENDING};
      ADDR_FRAME: rd_mux = frame_count;
      ADDR_ANIM:  rd_mux = {14'b0, anim_phase};
      default:    ;
    endcase
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      if (address == 5'(4 + 2*i)) rd_mux = {6'b0, stg_gx[i]};
      if (address == 5'(5 + 2*i)) rd_mux = {6'b0, stg_gy[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                  readdata <= '0;
    else if (chipselect & read) readdata <= rd_mux;
  end

  assign pacman_x   = live_px;
  assign pacman_y   = live_py;
  assign pacman_dir = live_dir;
  assign irq        = irq_q;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_pack
    assign ghost_x[10*g +: 10] = live_gx[g];
    assign ghost_y[10*g +: 10] = live_gy[g];
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, writedata[15:10]};

endmodule

// File: tb/tb_sprite_frame_regs.sv
// Directed bench for sprite_frame_regs: reset values, vblank-timed commit, map decode, counters, irq.
module tb_sprite_frame_regs;

  logic        clk = 1'b0;
  logic        reset, chipselect, write, read;
  logic [4:0]  address;
  logic [15:0] writedata, readdata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [9:0]  pacman_x, pacman_y;
  logic [1:0]  pacman_dir, anim_phase;
  logic [39:0] ghost_x, ghost_y;
  logic [15:0] frame_count;
  logic        irq;
  logic [15:0] rd_val;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  sprite_frame_regs #(.NUM_GHOSTS(4), .VACTIVE(480), .ANIM_DIV(8)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .hcount(hcount), .vcount(vcount),
    .pacman_x(pacman_x), .pacman_y(pacman_y), .pacman_dir(pacman_dir),
    .ghost_x(ghost_x), .ghost_y(ghost_y),
    .anim_phase(anim_phase), .frame_count(frame_count), .irq(irq)
  );

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk);
    #1 chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk);
    #1 chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic vb();
    vcount = 10'd480; hcount = 11'd0;
    @(posedge clk);
    #1 vcount = 10'd0; hcount = 11'd5;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pacman_x !== 10'd340) begin errors++; $display("FAIL reset_pac_x got %0d want 340", pacman_x); end
    checks++; if (pacman_y !== 10'd240) begin errors++; $display("FAIL reset_pac_y got %0d want 240", pacman_y); end
    checks++; if (pacman_dir !== 2'd1) begin errors++; $display("FAIL reset_pac_dir got %0d want 1", pacman_dir); end
    checks++; if (ghost_x !== {4{10'd300}}) begin errors++; $display("FAIL reset_ghost_x got %h want %h", ghost_x, {4{10'd300}}); end
    checks++; if (ghost_y !== {4{10'd240}}) begin errors++; $display("FAIL reset_ghost_y got %h want %h", ghost_y, {4{10'd240}}); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame got %0d want 0", frame_count); end
    checks++; if (anim_phase !== 2'd0) begin errors++; $display("FAIL reset_anim got %0d want 0", anim_phase); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++; if (readdata !== 16'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
    rd(5'd0, rd_val);
    checks++; if (rd_val !== 16'd340) begin errors++; $display("FAIL reset_stg_x got %0d want 340", rd_val); end
  endtask

  task automatic test_commit();
    do_reset();
    wr(5'd0, 16'd100);
    wr(5'd1, 16'd50);
    wr(5'd2, 16'd3);
    wr(5'd16, 16'd1);
    idle(3);
    checks++; if (pacman_x !== 10'd340) begin errors++; $display("FAIL commit_early_x got %0d want 340", pacman_x); end
    rd(5'd16, rd_val);
    checks++; if (rd_val !== 16'd1) begin errors++; $display("FAIL commit_pending got %h want 1", rd_val); end
    vb();
    checks++; if (pacman_x !== 10'd100) begin errors++; $display("FAIL commit_x got %0d want 100", pacman_x); end
    checks++; if (pacman_y !== 10'd50) begin errors++; $display("FAIL commit_y got %0d want 50", pacman_y); end
    checks++; if (pacman_dir !== 2'd3) begin errors++; $display("FAIL commit_dir got %0d want 3", pacman_dir); end
    rd(5'd16, rd_val);
    checks++; if (rd_val !== 16'd0) begin errors++; $display("FAIL commit_pending_clr got %h want 0", rd_val); end
    // A CTRL write with bit0 clear must not arm a commit.
    wr(5'd0, 16'd7);
    wr(5'd16, 16'd2);
    vb();
    checks++; if (pacman_x !== 10'd100) begin errors++; $display("FAIL ctrl_bit0_clear got %0d want 100", pacman_x); end
  endtask

  task automatic test_vb_coincident();
    do_reset();
    wr(5'd4, 16'd77);
    chipselect = 1'b1; write = 1'b1; address = 5'd16; writedata = 16'd1;
    vb();
    chipselect = 1'b0; write = 1'b0;
    checks++; if (ghost_x[9:0] !== 10'd300) begin errors++; $display("FAIL vbco_no_commit got %0d want 300", ghost_x[9:0]); end
    rd(5'd16, rd_val);
    checks++; if (rd_val !== 16'd1) begin errors++; $display("FAIL vbco_pending got %h want 1", rd_val); end
    chipselect = 1'b1; write = 1'b1; address = 5'd4; writedata = 16'd99;
    vb();
    chipselect = 1'b0; write = 1'b0;
    checks++; if (ghost_x[9:0] !== 10'd77) begin errors++; $display("FAIL vbco_commit got %0d want 77", ghost_x[9:0]); end
    checks++; if (ghost_x[39:10] !== {3{10'd300}}) begin errors++; $display("FAIL vbco_others got %h want %h", ghost_x[39:10], {3{10'd300}}); end
    rd(5'd4, rd_val);
    checks++; if (rd_val !== 16'd99) begin errors++; $display("FAIL vbco_staging got %0d want 99", rd_val); end
  endtask

  task automatic test_anim();
    do_reset();
    for (int f = 1; f <= 33; f++) begin
      vb();
      idle(1);
      if (f == 8) begin
        checks++; if (anim_phase !== 2'd1) begin errors++; $display("FAIL anim_f8 got %0d want 1", anim_phase); end
      end
      if (f == 7) begin
        checks++; if (anim_phase !== 2'd0) begin errors++; $display("FAIL anim_f7 got %0d want 0", anim_phase); end
      end
    end
    checks++; if (frame_count !== 16'd33) begin errors++; $display("FAIL frame_33 got %0d want 33", frame_count); end
    checks++; if (anim_phase !== 2'd0) begin errors++; $display("FAIL anim_33 got %0d want 0", anim_phase); end
    rd(5'd17, rd_val);
    checks++; if (rd_val !== 16'd33) begin errors++; $display("FAIL rd_frame got %0d want 33", rd_val); end
    rd(5'd18, rd_val);
    checks++; if (rd_val !== 16'd0) begin errors++; $display("FAIL rd_anim got %0d want 0", rd_val); end
  endtask

  task automatic test_map();
    do_reset();
    wr(5'd12, 16'h0123);
    wr(5'd25, 16'h0055);
    wr(5'd3, 16'h0011);
    rd(5'd12, rd_val);
    checks++; if (rd_val !== 16'd0) begin errors++; $display("FAIL map_rd12 got %h want 0", rd_val); end
    rd(5'd25, rd_val);
    checks++; if (rd_val !== 16'd0) begin errors++; $display("FAIL map_rd25 got %h want 0", rd_val); end
    rd(5'd3, rd_val);
    checks++; if (rd_val !== 16'd0) begin errors++; $display("FAIL map_rd3 got %h want 0", rd_val); end
    wr(5'd1, 16'hFEDC);
    wr(5'd11, 16'd222);
    rd(5'd1, rd_val);
    checks++; if (rd_val !== 16'h02DC) begin errors++; $display("FAIL map_rd1 got %h want 02dc", rd_val); end
    address = 5'd11;
    idle(2);
    checks++; if (readdata !== 16'h02DC) begin errors++; $display("FAIL map_hold got %h want 02dc", readdata); end
    rd(5'd11, rd_val);
    checks++; if (rd_val !== 16'd222) begin errors++; $display("FAIL map_rd11 got %0d want 222", rd_val); end
    wr(5'd16, 16'd1);
    vb();
    checks++; if (ghost_y !== {10'd222, {3{10'd240}}}) begin errors++; $display("FAIL map_ghost_y got %h want %h", ghost_y, {10'd222, {3{10'd240}}}); end
    checks++; if (ghost_x !== {4{10'd300}}) begin errors++; $display("FAIL map_ghost_x got %h want %h", ghost_x, {4{10'd300}}); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    wr(5'd0, 16'd5);
    wr(5'd16, 16'd1);
    do_reset();
    vb();
    checks++; if (pacman_x !== 10'd340) begin errors++; $display("FAIL rstpend_x got %0d want 340", pacman_x); end
    rd(5'd16, rd_val);
    checks++; if (rd_val !== 16'd0) begin errors++; $display("FAIL rstpend_pending got %h want 0", rd_val); end
  endtask

  task automatic test_irq();
    do_reset();
    wr(5'd16, 16'd1);
    vb();
`ifdef SPRITE_FRAME_REGS_IRQ_EN
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
    rd(5'd16, rd_val);
    checks++; if (rd_val !== 16'd2) begin errors++; $display("FAIL irq_status got %h want 2", rd_val); end
    wr(5'd19, 16'd0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ack got %b want 0", irq); end
    wr(5'd16, 16'd1);
    chipselect = 1'b1; write = 1'b1; address = 5'd19; writedata = 16'd0;
    vb();
    chipselect = 1'b0; write = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b want 1", irq); end
`else
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off_commit got %b want 0", irq); end
    rd(5'd16, rd_val);
    checks++; if (rd_val !== 16'd0) begin errors++; $display("FAIL irq_off_status got %h want 0", rd_val); end
    wr(5'd19, 16'd1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off_ack got %b want 0", irq); end
`endif
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; hcount = 11'd5; vcount = 10'd0;
    test_reset();
    test_commit();
    test_vb_coincident();
    test_anim();
    test_map();
    test_reset_pending();
    test_irq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
